pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline stall/flush controller for the N-stage in-order core, the successor to the fixed 7-stage controller.
//  It priority-resolves freeze sources (TLB/cache/mul-div), exception flush, branch-mispredict flush and N data-hazard

---
 rtl/pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the N-stage in-order core.
// Resolves freeze, exception, mispredict and data-hazard requests into
// per-stage write-enable / flush / write-disable vectors, plus cache handshakes.
// Flush pulses seen while frozen are held in pend_* until the pipe moves again.
// Optional build macro: PIPE_HAZARD_PERF_EN adds three performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 7,
  parameter int unsigned NUM_FRZ    = 5,
  parameter int unsigned ID_IDX     = 2,
  parameter int unsigned NUM_DH     = 3,
  parameter int unsigned EXC_IDX    = 4,
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FRZ-1:0]    freeze_req,
  input  logic                  exc_flush,
  input  logic                  bp_fail,
  input  logic                  bp_flush_all,
  input  logic                  bp_kill_exe,
  input  logic [NUM_DH-1:0]     dh_stall,
  output logic [NUM_STAGES-1:0] stage_wr,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_diswr,
  output logic                  ireq_valid,
  output logic                  dreq_valid,
  output logic                  icache_stall,
  output logic                  dcache_stall,
  output logic                  frozen,
  output logic                  wdog_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_frz_cyc,
  output logic [PERF_W-1:0]     perf_dh_cyc,
  output logic [PERF_W-1:0]     perf_flush_cnt
`endif
);

  localparam int unsigned WCW = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_LIMIT - 1);

  if ((ID_IDX + NUM_DH >= NUM_STAGES) || (EXC_IDX >= NUM_STAGES) ||
      (EXC_IDX <= ID_IDX) || (PERF_W == 0) || (WDOG_LIMIT == 0)) begin : g_param_err
    $error("pipe_hazard_ctrl: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    M_NORMAL,
    M_FREEZE,
    M_EXC,
    M_ALL,
    M_DH,
    M_BP
  } mode_t;

  logic           pend_exc;
  logic           pend_bp;
  logic           pend_all;
  logic           frz;
  logic           exc_e;
  logic           bp_e;
  logic           all_e;
  logic           dh_any;
  int unsigned    dh_idx;
  mode_t          mode;
  logic [WCW-1:0] wdog_cnt;

  // Effective requests and priority selection of the applied pattern
  always_comb begin
    frz    = |freeze_req;
    exc_e  = exc_flush | pend_exc;
    bp_e   = bp_fail | pend_bp;
    all_e  = bp_flush_all | pend_all;
    dh_any = |dh_stall;
    dh_idx = 0;
    for (int unsigned i = 0; i < NUM_DH; i++) begin
      if (dh_stall[i]) dh_idx = i;
    end
    if (frz)         mode = M_FREEZE;
    else if (exc_e)  mode = M_EXC;
    else if (all_e)  mode = M_ALL;
    else if (dh_any) mode = M_DH;
    else if (bp_e)   mode = M_BP;
    else             mode = M_NORMAL;
  end

  // Per-stage control vectors and cache handshakes; reset forces a safe state
  always_comb begin
    stage_wr    = '1;
    stage_flush = '0;
    stage_diswr = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      case (mode)
        M_FREEZE: begin
          stage_wr[k]    = 1'b0;
          stage_diswr[k] = (k >= ID_IDX + 1);
        end
        M_EXC: begin
          stage_wr[k]    = !((k >= 1) && (k <= EXC_IDX));
          stage_flush[k] = (k >= 1) && (k <= EXC_IDX);
          stage_diswr[k] = (k >= ID_IDX + 1) && (k <= EXC_IDX);
        end
        M_ALL: begin
          stage_wr[k]    = !((k >= 1) && (k <= ID_IDX));
          stage_flush[k] = (k >= 1) && (k <= ID_IDX + 1);
        end
        M_DH: begin
          stage_wr[k]    = (k > ID_IDX + dh_idx);
          stage_flush[k] = (k == ID_IDX + 1 + dh_idx);
          stage_diswr[k] = ((k >= ID_IDX + 1) && (k <= ID_IDX + dh_idx)) ||
                           ((dh_idx == 0) && (k == ID_IDX));
        end
        M_BP: begin
          stage_wr[k]    = !((k >= 1) && (k <= ID_IDX));
          stage_flush[k] = ((k >= 1) && (k <= ID_IDX)) ||
                           ((k == ID_IDX + 1) && bp_kill_exe);
        end
        default: begin
          stage_flush[k] = (k == ID_IDX + 1) && bp_kill_exe;
        end
      endcase
    end

    ireq_valid   = !(exc_e || all_e || bp_e || dh_any);
    dreq_valid   = !exc_e;
    dcache_stall = frz;
    if (frz)                 icache_stall = 1'b1;
    else if (exc_e || all_e) icache_stall = 1'b0;
    else                     icache_stall = dh_any;
    frozen = frz;

    if (rst) begin
      stage_wr     = '0;
      stage_flush  = '1;
      stage_diswr  = '0;
      ireq_valid   = 1'b0;
      dreq_valid   = 1'b0;
      icache_stall = 1'b0;
      dcache_stall = 1'b0;
    end
  end

  // Hold flush requests that arrive while frozen; the first moving cycle consumes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_exc <= 1'b0;
      pend_bp  <= 1'b0;
      pend_all <= 1'b0;
    end else if (frz) begin
      if (exc_flush) begin
        // an exception supersedes any held mispredict
        pend_exc <= 1'b1;
        pend_bp  <= 1'b0;
        pend_all <= 1'b0;
      end else begin
        pend_bp  <= pend_bp | bp_fail;
        pend_all <= pend_all | bp_flush_all;
      end
    end else begin
      pend_exc <= 1'b0;
      pend_bp  <= 1'b0;
      pend_all <= 1'b0;
    end
  end

  // Freeze watchdog: count consecutive frozen cycles, flag a sticky timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt     <= '0;
      wdog_timeout <= 1'b0;
    end else if (frz) begin
      if (wdog_cnt != WDOG_LAST) wdog_cnt <= wdog_cnt + WCW'(1);
      if (wdog_cnt == WDOG_LAST) wdog_timeout <= 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Performance counters: frozen cycles, dh-stall cycles, applied flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_frz_cyc   <= '0;
      perf_dh_cyc    <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (mode == M_FREEZE) perf_frz_cyc <= perf_frz_cyc + PERF_W'(1);
      if (mode == M_DH)     perf_dh_cyc  <= perf_dh_cyc + PERF_W'(1);
      if ((mode == M_EXC) || (mode == M_ALL) || (mode == M_BP))
        perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (7 stages, ID=2, EXC=4, 3 dh sources, WDOG_LIMIT=4).
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] freeze_req;
  logic       exc_flush;
  logic       bp_fail;
  logic       bp_flush_all;
  logic       bp_kill_exe;
  logic [2:0] dh_stall;
  logic [6:0] stage_wr;
  logic [6:0] stage_flush;
  logic [6:0] stage_diswr;
  logic       ireq_valid;
  logic       dreq_valid;
  logic       icache_stall;
  logic       dcache_stall;
  logic       frozen;
  logic       wdog_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_frz_cyc;
  logic [31:0] perf_dh_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(
    .NUM_STAGES(7),
    .NUM_FRZ(5),
    .ID_IDX(2),
    .NUM_DH(3),
    .EXC_IDX(4),
    .WDOG_LIMIT(4),
    .PERF_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .freeze_req(freeze_req),
    .exc_flush(exc_flush),
    .bp_fail(bp_fail),
    .bp_flush_all(bp_flush_all),
    .bp_kill_exe(bp_kill_exe),
    .dh_stall(dh_stall),
    .stage_wr(stage_wr),
    .stage_flush(stage_flush),
    .stage_diswr(stage_diswr),
    .ireq_valid(ireq_valid),
    .dreq_valid(dreq_valid),
    .icache_stall(icache_stall),
    .dcache_stall(dcache_stall),
    .frozen(frozen),
    .wdog_timeout(wdog_timeout)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_frz_cyc(perf_frz_cyc),
    .perf_dh_cyc(perf_dh_cyc),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] frz;
    logic       exc;
    logic       bp;
    logic       fa;
    logic       kill;
    logic [2:0] dh;
    logic [6:0] wr;
    logic [6:0] fl;
    logic [6:0] dw;
    logic [4:0] fg;   // {ireq, dreq, istall, dstall, frozen}
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] f, input logic e, input logic b, input logic a,
                     input logic k, input logic [2:0] d);
    freeze_req   = f;
    exc_flush    = e;
    bp_fail      = b;
    bp_flush_all = a;
    bp_kill_exe  = k;
    dh_stall     = d;
  endtask

  task automatic pat(input string nm, input logic [6:0] wr, input logic [6:0] fl,
                     input logic [6:0] dw);
    chk({nm, ".wr"}, {25'd0, stage_wr}, {25'd0, wr});
    chk({nm, ".flush"}, {25'd0, stage_flush}, {25'd0, fl});
    chk({nm, ".diswr"}, {25'd0, stage_diswr}, {25'd0, dw});
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        frz       exc  bp   fa   kill dh      wr          flush       diswr       flags
    vt[0]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 7'b1111111, 7'b0000000, 7'b0000000, 5'b11000};
    vt[1]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 7'b1110000, 7'b0010000, 7'b0001000, 5'b01100};
    vt[2]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 7'b1111000, 7'b0001000, 7'b0000100, 5'b01100};
    vt[3]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 7'b1100000, 7'b0100000, 7'b0011000, 5'b01100};
    vt[4]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 7'b1100000, 7'b0100000, 7'b0011000, 5'b01100};
    vt[5]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 7'b1100001, 7'b0011110, 7'b0011000, 5'b00000};
    vt[6]  = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 7'b1111001, 7'b0000110, 7'b0000000, 5'b01000};
    vt[7]  = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 7'b1111001, 7'b0001110, 7'b0000000, 5'b01000};
    vt[8]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 7'b1111111, 7'b0001000, 7'b0000000, 5'b11000};
    vt[9]  = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 7'b1111001, 7'b0001110, 7'b0000000, 5'b01000};
    vt[10] = '{5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 7'b1111001, 7'b0001110, 7'b0000000, 5'b01000};
    vt[11] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 7'b1110000, 7'b0010000, 7'b0001000, 5'b01100};
    vt[12] = '{5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 7'b0000000, 7'b0000000, 7'b1111000, 5'b11111};
    vt[13] = '{5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 7'b0000000, 7'b0000000, 7'b1111000, 5'b01111};
    vt[14] = '{5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 7'b1100001, 7'b0011110, 7'b0011000, 5'b00000};

    // reset state, with a data hazard driven to show the reset override
    rst = 1'b1;
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111);
    #12;
    pat("reset", 7'b0000000, 7'b1111111, 7'b0000000);
    chk("reset.flags", {27'd0, ireq_valid, dreq_valid, icache_stall, dcache_stall, frozen}, 32'h0);
    chk("reset.wdog", {31'd0, wdog_timeout}, 32'h0);
    next_cyc();
    rst = 1'b0;
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    next_cyc();

    // single-cycle patterns
    for (int i = 0; i < 15; i++) begin
      drv(vt[i].frz, vt[i].exc, vt[i].bp, vt[i].fa, vt[i].kill, vt[i].dh);
      #4;
      pat($sformatf("vec%0d", i), vt[i].wr, vt[i].fl, vt[i].dw);
      chk($sformatf("vec%0d.flags", i),
          {27'd0, ireq_valid, dreq_valid, icache_stall, dcache_stall, frozen},
          {27'd0, vt[i].fg});
      next_cyc();
    end
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    next_cyc();

    // exception pulse during a 3-cycle freeze is applied on release
    drv(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    chk("frz1.wr", {25'd0, stage_wr}, 32'h0);
    next_cyc();
    drv(5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    chk("frz2.wr", {25'd0, stage_wr}, 32'h0);
    next_cyc();
    drv(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    chk("frz3.wr", {25'd0, stage_wr}, 32'h0);
    next_cyc();
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    pat("frz_rel", 7'b1100001, 7'b0011110, 7'b0011000);
    chk("frz_rel.dreq", {31'd0, dreq_valid}, 32'h0);
    next_cyc();
    #4;
    pat("frz_after", 7'b1111111, 7'b0000000, 7'b0000000);
    chk("frz_after.dreq", {31'd0, dreq_valid}, 32'h1);
    next_cyc();

    // mispredict then exception during freeze: exception wins, then pipe is clean
    drv(5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000); next_cyc();
    drv(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000); next_cyc();
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    pat("bpexc_rel", 7'b1100001, 7'b0011110, 7'b0011000);
    chk("bpexc_rel.ireq", {31'd0, ireq_valid}, 32'h0);
    next_cyc();
    #4;
    pat("bpexc_after", 7'b1111111, 7'b0000000, 7'b0000000);
    chk("bpexc_after.ireq", {31'd0, ireq_valid}, 32'h1);
    next_cyc();

    // held mispredict alone is applied on release
    drv(5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000); next_cyc();
    drv(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); next_cyc();
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    pat("bp_rel", 7'b1111001, 7'b0000110, 7'b0000000);
    next_cyc();

    // held flush-all is applied on release
    drv(5'b00001, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000); next_cyc();
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    pat("all_rel", 7'b1111001, 7'b0001110, 7'b0000000);
    next_cyc();

    // watchdog: broken 3-cycle freezes never time out
    for (int r = 0; r < 2; r++) begin
      drv(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      repeat (3) next_cyc();
      drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      next_cyc();
    end
    #4;
    chk("wdog_short", {31'd0, wdog_timeout}, 32'h0);
    next_cyc();

    // watchdog: 4 consecutive frozen cycles set the sticky timeout
    drv(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (3) next_cyc();
    #4;
    chk("wdog_c4", {31'd0, wdog_timeout}, 32'h0);
    next_cyc();
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    chk("wdog_set", {31'd0, wdog_timeout}, 32'h1);
    next_cyc();
    #4;
    chk("wdog_sticky", {31'd0, wdog_timeout}, 32'h1);
    next_cyc();

    // asynchronous reset mid-freeze clears timeout and held exception
    drv(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000); next_cyc();
    drv(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.wdog", {31'd0, wdog_timeout}, 32'h0);
    pat("arst", 7'b0000000, 7'b1111111, 7'b0000000);
    next_cyc();
    rst = 1'b0;
    drv(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000); #4;
    pat("arst_rel", 7'b1111111, 7'b0000000, 7'b0000000);
    chk("arst_rel.dreq", {31'd0, dreq_valid}, 32'h1);
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
